// File: rtl/ca_rule_scheduler.sv
// Frame sequencer for the 1-D cellular-automaton VGA datapath: picks the rule/colour
// band per cell row, controls seed/run/pause/step evolution and commits table writes in vblank.
module ca_rule_scheduler #(
   parameter int NUM_RULES = 16,
   parameter int CELL_LOG2 = 2,
   parameter int BAND_LOG2 = 3,
   parameter int GRID_ROWS = 120
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         line_strobe,
   input  logic [9:0]                   line_idx,
   input  logic                         vblank_strobe,
   input  logic                         run_en,
   input  logic                         step_req,
   input  logic                         reseed_req,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [$clog2(NUM_RULES)-1:0] cfg_addr,
   input  logic [7:0]                   cfg_rule,
   input  logic [5:0]                   cfg_color,
   output logic [7:0]                   rule,
   output logic [5:0]                   rule_color,
   output logic                         seed_load,
   output logic                         advance_en,
   output logic [$clog2(NUM_RULES)-1:0] band_idx,
   output logic [15:0]                  frame_count
);

   localparam int IDX_W    = $clog2(NUM_RULES);
   localparam int BASE_MOD = NUM_RULES << BAND_LOG2;
   localparam int BASE_W   = $clog2(BASE_MOD);
   localparam logic [9:0] LINE_LIMIT = 10'(GRID_ROWS << CELL_LOG2);
   localparam logic [7:0] RULE_EVEN  = 8'd30;
   localparam logic [7:0] RULE_ODD   = 8'd110;
   localparam logic [5:0] COLOR_EVEN = 6'b001011;
   localparam logic [5:0] COLOR_ODD  = 6'b101100;

   typedef enum logic [1:0] {
      SEED  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      STEP  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                step_flag_r;
   logic                reseed_flag_r;
   logic [BASE_W-1:0]   base_row_r;
   logic [10:0]         row_sum_s;
   logic [IDX_W-1:0]    band_s;
   logic                line_hit_s;

   logic [7:0] act_rule_r  [NUM_RULES];
   logic [5:0] act_color_r [NUM_RULES];
   logic [7:0] shd_rule_r  [NUM_RULES];
   logic [5:0] shd_color_r [NUM_RULES];

   assign cfg_ready = ~vblank_strobe;

   // Next-state selection; only consulted on vblank_strobe, reseed overrides everything
   always_comb begin
      state_nxt_s = state_r;
      if (reseed_flag_r) begin
         state_nxt_s = SEED;
      end else begin
         case (state_r)
            SEED:    state_nxt_s = run_en ? RUN : PAUSE;
            RUN:     state_nxt_s = run_en ? RUN : PAUSE;
            PAUSE: begin
               if (run_en) begin
                  state_nxt_s = RUN;
               end else if (step_flag_r) begin
                  state_nxt_s = STEP;
               end else begin
                  state_nxt_s = PAUSE;
               end
            end
            STEP:    state_nxt_s = PAUSE;
            default: state_nxt_s = SEED;
         endcase
      end
   end

   // Band lookup for the cell row starting on this line
   always_comb begin
      row_sum_s  = 11'(base_row_r) + 11'(line_idx >> CELL_LOG2);
      band_s     = IDX_W'(row_sum_s >> BAND_LOG2);
      line_hit_s = line_strobe && !vblank_strobe &&
                   (line_idx[CELL_LOG2-1:0] == '0) && (line_idx < LINE_LIMIT);
   end

   // State, evolution outputs, frame counter and sticky request flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= SEED;
         seed_load     <= 1'b1;
         advance_en    <= 1'b0;
         frame_count   <= 16'd0;
         base_row_r    <= '0;
         step_flag_r   <= 1'b0;
         reseed_flag_r <= 1'b0;
      end else begin
         if (vblank_strobe) begin
            state_r    <= state_nxt_s;
            seed_load  <= (state_nxt_s == SEED);
            advance_en <= (state_nxt_s == RUN) || (state_nxt_s == STEP);
            if (advance_en) begin
               frame_count <= frame_count + 16'd1;
               base_row_r  <= (base_row_r == BASE_W'(BASE_MOD - 1)) ? '0 : base_row_r + 1'b1;
            end
            if ((state_r == PAUSE) || reseed_flag_r) begin
               step_flag_r <= 1'b0;
            end
            reseed_flag_r <= 1'b0;
         end
         // A new request in the same cycle as a consuming vblank stays latched for the next frame
         if (step_req && ((state_r == PAUSE) || (state_r == SEED))) begin
            step_flag_r <= 1'b1;
         end
         if (reseed_req) begin
            reseed_flag_r <= 1'b1;
         end
      end
   end

   // Shadow table takes writes; active table is refreshed wholesale in vblank
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            act_rule_r[i]  <= (i % 2 == 1) ? RULE_ODD : RULE_EVEN;
            act_color_r[i] <= (i % 2 == 1) ? COLOR_ODD : COLOR_EVEN;
            shd_rule_r[i]  <= (i % 2 == 1) ? RULE_ODD : RULE_EVEN;
            shd_color_r[i] <= (i % 2 == 1) ? COLOR_ODD : COLOR_EVEN;
         end
      end else begin
         if (vblank_strobe) begin
            for (int i = 0; i < NUM_RULES; i++) begin
               act_rule_r[i]  <= shd_rule_r[i];
               act_color_r[i] <= shd_color_r[i];
            end
         end
         if (cfg_valid && cfg_ready) begin
            shd_rule_r[cfg_addr]  <= cfg_rule;
            shd_color_r[cfg_addr] <= cfg_color;
         end
      end
   end

   // Per-row rule/colour outputs, updated one cycle after a qualifying line strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         band_idx   <= '0;
         rule       <= RULE_EVEN;
         rule_color <= COLOR_EVEN;
      end else if (line_hit_s) begin
         band_idx   <= band_s;
         rule       <= act_rule_r[band_s];
         rule_color <= act_color_r[band_s];
      end
   end

endmodule

// File: doc/ca_rule_scheduler.md
Name: ca_rule_scheduler

Overview:
- Sequencer for the 1-D cellular-automaton VGA datapath.
- Owns a 16-entry table of rule and colour pairs. Per displayed cell row it selects which rule and colour drive the CA datapath, so bands of rows use different rules.
- Controls frame evolution (seed, run, pause, single-step) and scrolls the rule bands with the content.
- Provides a valid/ready configuration port that stages table writes and commits them only during vertical blanking.

Parameters:
- NUM_RULES, 16, table depth; power of two.
- CELL_LOG2, 2, log2 of pixel lines per cell row.
- BAND_LOG2, 3, log2 of cell rows per rule band.
- GRID_ROWS, 120, visible cell rows per frame.

Ports:
- clk, input, 1, pixel clock.
- reset, input, 1, synchronous, active-high reset.
- line_strobe, input, 1, one-cycle pulse at the start of each visible pixel line.
- line_idx, input, 10, pixel line number; valid with line_strobe.
- vblank_strobe, input, 1, one-cycle pulse at the first line of vertical blanking.
- run_en, input, 1, level: free-run evolution.
- step_req, input, 1, pulse: advance exactly one frame while paused.
- reseed_req, input, 1, pulse: restart from the single-cell seed.
- cfg_valid, input, 1, table write request.
- cfg_ready, output, 1, write accepted when valid and ready are both high.
- cfg_addr, input, 4, table entry.
- cfg_rule, input, 8, Wolfram rule number.
- cfg_color, input, 6, RRGGBB colour.
- rule, output, 8, rule for the current cell row.
- rule_color, output, 6, colour for the current cell row.
- seed_load, output, 1, datapath loads the seed this frame instead of next_cells.
- advance_en, output, 1, datapath captures next_cells this frame.
- band_idx, output, 4, current table index.
- frame_count, output, 16, count of advanced frames; wraps.

Behaviour:
- Reset values:
  - state = SEED; seed_load = 1; advance_en = 0; frame_count = 0; base_row = 0.
  - band_idx = 0; rule = 30; rule_color = 6'b001011; cfg_ready = 1.
  - Both tables reset to: even entries rule 30 / colour 001011; odd entries rule 110 / colour 101100.
- The reset cycle overrides all other inputs. Reset mid-frame takes effect on the next edge; outputs hold reset values until the next event.
- States: SEED, RUN, PAUSE, STEP. All transitions occur only on vblank_strobe.
  - SEED -> RUN if run_en, else PAUSE.
  - RUN -> PAUSE if !run_en.
  - PAUSE -> RUN if run_en; -> STEP if a step request is latched.
  - STEP -> PAUSE.
- Any latched reseed request moves to SEED and overrides every other transition.
- Request latching: step_req and reseed_req are latched into sticky flags and cleared at the vblank where they are consumed. step_req is ignored unless state is PAUSE or SEED; it is consumed in PAUSE only.
- Outputs per state, registered and changing on the cycle after the transition edge:
  - SEED: seed_load = 1, advance_en = 0.
  - RUN and STEP: seed_load = 0, advance_en = 1.
  - PAUSE: seed_load = 0, advance_en = 0.
- Frame counting: when leaving a state in which advance_en was 1, frame_count += 1 and base_row = (base_row + 1) mod (NUM_RULES << BAND_LOG2).
- Band selection:
  - On line_strobe with line_idx[CELL_LOG2-1:0] == 0: cell_row = line_idx >> CELL_LOG2.
  - band_idx = ((base_row + cell_row) >> BAND_LOG2) mod NUM_RULES.
  - rule and rule_color are driven from the active table.
- Latency: band_idx, rule and rule_color change exactly 1 cycle after the qualifying line_strobe. They are held stable at all other times, including non-boundary lines and blanking.
- line_idx >= GRID_ROWS << CELL_LOG2 is ignored.
- Config port:
  - An accepted write updates the shadow table only.
  - On vblank_strobe, the whole shadow table is copied to the active table in one cycle.
  - cfg_ready = 0 in the vblank_strobe cycle and 1 otherwise. A write presented during vblank_strobe stalls one cycle and lands in the next commit.
  - Two writes to the same address before a commit: last write wins.
- Simultaneous line_strobe and vblank_strobe cannot legally occur. If they do, vblank processing wins and the line is ignored.

Test Plan:
- Reset, then line_strobe at lines 0, 32 and 64 -> band_idx 0, 1, 2; rule 30, 110, 30; colours 001011, 101100, 001011; each 1 cycle after its strobe.
- run_en = 1, then 3 vblank_strobes -> first: SEED -> RUN; seed_load 1 -> 0; advance_en = 1; frame_count = 2 after the third. Line 0 then yields band_idx 0 (base_row 2, cell_row 0). After 6 advanced frames, line 8 (cell_row 2) -> band_idx 1.
- run_en = 0 in PAUSE; pulse step_req mid-frame -> next vblank: STEP with advance_en = 1; following vblank: PAUSE with advance_en = 0; frame_count +1 exactly once.
- Write addr 1 = rule 90, colour 111111 mid-frame -> line 32 still gives rule 110. After vblank_strobe, line 32 gives rule 90 / 111111.
- Hold cfg_valid during the vblank_strobe cycle -> cfg_ready = 0 that cycle; the write is accepted the next cycle and is visible only after the following vblank.
- In RUN, pulse reseed_req and step_req together -> next vblank: SEED, seed_load = 1, step discarded. Assert reset mid-frame -> all outputs return to reset values on the next edge.
